// File: rtl/key_event_if.sv
// Key event bundle: the debounced key level in, single-cycle key events and the held level out.
// Ports: key_i (level, 1 = pressed); press, release_evt, long_press, repeat_evt (1-cycle pulses); held (level).
// release/repeat are SystemVerilog keywords, so those two events carry an _evt suffix.
interface key_event_if;
    logic key_i;
    logic press;
    logic release_evt;
    logic long_press;
    logic repeat_evt;
    logic held;

    // Event generator side
    modport master (
        input  key_i,
        output press,
        output release_evt,
        output long_press,
        output repeat_evt,
        output held
    );

    // Debouncer/consumer side: drives the level, consumes the events
    modport slave (
        output key_i,
        input  press,
        input  release_evt,
        input  long_press,
        input  repeat_evt,
        input  held
    );
endinterface

// File: rtl/key_event_gen.sv
// Turns a debounced key level into press/release/long-press/auto-repeat pulses plus a held level.
// Latency: every output is registered, 1 cycle after the clock edge that samples the causing condition.
// Backpressure: none; each pulse is 1 cycle wide and must be consumed when it is issued.
// Ports: clk, rst_n (async, active low), kif (key_event_if.master: key_i in, events and held out).
module key_event_gen #(
    parameter int   CLK_FREQ   = 100,   // MHz
    parameter int   LONG_MS    = 1000,  // >= 1
    parameter int   REPEAT_MS  = 200,   // 0 disables auto-repeat
    parameter logic INIT_VALUE = 1'b0
) (
    input logic         clk,
    input logic         rst_n,
    key_event_if.master kif
);

    localparam int TICK_CYC = CLK_FREQ * 1000;
    localparam int PW       = (TICK_CYC > 1) ? $clog2(TICK_CYC) : 1;
    localparam int MS_MAXV  = (LONG_MS > REPEAT_MS) ? LONG_MS : REPEAT_MS;
    localparam int MS_W     = (MS_MAXV > 1) ? $clog2(MS_MAXV + 1) : 1;

    localparam logic [PW-1:0]   TICK_LAST   = PW'(TICK_CYC - 1);
    localparam logic [MS_W-1:0] MS_MAX      = {MS_W{1'b1}};
    // Thresholds are matched one count early, together with the tick that would
    // complete them, so the pulse lands exactly LONG_MS / REPEAT_MS ticks after the edge.
    localparam logic [MS_W-1:0] LONG_LAST   = MS_W'(LONG_MS - 1);
    localparam logic [MS_W-1:0] REPEAT_LAST = MS_W'((REPEAT_MS > 0) ? REPEAT_MS - 1 : 0);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        LONG = 2'd2
    } state_t;

    state_t          state, state_nxt;
    logic            key_prev;
    logic            armed;
    logic [PW-1:0]   presc, presc_nxt;
    logic [MS_W-1:0] ms_cnt, ms_nxt, ms_sat;
    logic            tick;
    logic            press_nxt, release_nxt, long_nxt, repeat_nxt;

    // A level of 1 right after reset may be a hold that began before reset, so a
    // press is only accepted once the key has been seen released since reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_prev <= INIT_VALUE;
            armed    <= 1'b0;
        end else begin
            key_prev <= kif.key_i;
            if (!kif.key_i) begin
                armed <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            presc           <= '0;
            ms_cnt          <= '0;
            kif.press       <= 1'b0;
            kif.release_evt <= 1'b0;
            kif.long_press  <= 1'b0;
            kif.repeat_evt  <= 1'b0;
            kif.held        <= 1'b0;
        end else begin
            state           <= state_nxt;
            presc           <= presc_nxt;
            ms_cnt          <= ms_nxt;
            kif.press       <= press_nxt;
            kif.release_evt <= release_nxt;
            kif.long_press  <= long_nxt;
            kif.repeat_evt  <= repeat_nxt;
            kif.held        <= (state_nxt != IDLE);
        end
    end

    always_comb begin
        state_nxt   = state;
        presc_nxt   = presc;
        ms_nxt      = ms_cnt;
        press_nxt   = 1'b0;
        release_nxt = 1'b0;
        long_nxt    = 1'b0;
        repeat_nxt  = 1'b0;
        tick        = (state != IDLE) && (presc == TICK_LAST);
        // Saturate rather than wrap: with repeat disabled LONG never clears it.
        ms_sat      = (ms_cnt == MS_MAX) ? ms_cnt : ms_cnt + 1'b1;

        case (state)
            IDLE: begin
                presc_nxt = '0;
                ms_nxt    = '0;
                if (armed && kif.key_i && !key_prev) begin
                    press_nxt = 1'b1;
                    state_nxt = HOLD;
                end
            end
            HOLD, LONG: begin
                if (!kif.key_i) begin
                    // Release wins over any threshold on the same edge.
                    release_nxt = 1'b1;
                    state_nxt   = IDLE;
                    presc_nxt   = '0;
                    ms_nxt      = '0;
                end else begin
                    presc_nxt = tick ? '0 : presc + 1'b1;
                    if (tick) begin
                        ms_nxt = ms_sat;
                    end
                    if (state == HOLD) begin
                        if (tick && ms_cnt == LONG_LAST) begin
                            long_nxt  = 1'b1;
                            state_nxt = LONG;
                            ms_nxt    = '0;
                        end
                    end else if (REPEAT_MS != 0) begin
                        if (tick && ms_cnt == REPEAT_LAST) begin
                            repeat_nxt = 1'b1;
                            ms_nxt     = '0;
                        end
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                presc_nxt = '0;
                ms_nxt    = '0;
            end
        endcase
    end

endmodule
